// File: rtl/mux4_rr_arbiter_pkg.sv
// Shared constants and types for the 4-requester round-robin arbiter family.
// Holds the state encoding, counter widths and a one-hot grant helper.
package mux4_rr_arbiter_pkg;

  localparam int NREQ       = 4;
  localparam int SEL_W      = 2;
  localparam int HOLD_CNT_W = 8;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } arb_state_t;

  function automatic logic [NREQ-1:0] onehot_of(input logic [SEL_W-1:0] idx);
    logic [NREQ-1:0] v;
    v = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/mux4_rr_arbiter_rr_pick4.sv
// Combinational rotating-priority picker: first set req bit at or after ptr.
// Scans ptr, ptr+1, ptr+2, ptr+3 modulo 4.
module rr_pick4
  import mux4_rr_arbiter_pkg::*;
(
  input  logic [NREQ-1:0]  req,
  input  logic [SEL_W-1:0] ptr,
  output logic             any,
  output logic [SEL_W-1:0] idx
);

  logic [SEL_W-1:0] cand;

  // Walk from the farthest offset back to ptr so the nearest hit is kept.
  always_comb begin
    any  = 1'b0;
    idx  = ptr;
    cand = ptr;
    for (int k = NREQ - 1; k >= 0; k--) begin
      cand = ptr + SEL_W'(k);
      if (req[cand]) begin
        any = 1'b1;
        idx = cand;
      end
    end
  end

endmodule

// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter driving the shared 4:1 selector, with a valid/ready
// output and a per-grant transfer limit so no requester can starve the rest.
//
//   state    | meaning
//   ---------+--------------------------------------------------------------
//   ST_IDLE  | no grant; arbitrate among req starting at ptr
//   ST_GRANT | sel owns the output; count transfers until drop or MAX_HOLD
module mux4_rr_arbiter
  import mux4_rr_arbiter_pkg::*;
#(
  parameter int DATA_W   = 1,
  parameter int MAX_HOLD = 8
)
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NREQ-1:0]        req,
  input  logic [NREQ*DATA_W-1:0] data,
  input  logic                   ready,
  output logic [NREQ-1:0]        gnt,
  output logic [SEL_W-1:0]       sel,
  output logic                   out_valid,
  output logic [DATA_W-1:0]      out_data
);

  localparam logic [HOLD_CNT_W-1:0] HOLD_LAST = HOLD_CNT_W'(MAX_HOLD - 1);

  arb_state_t            state, state_d;
  logic [NREQ-1:0]       gnt_d;
  logic [SEL_W-1:0]      sel_d;
  logic [SEL_W-1:0]      ptr, ptr_d;
  logic [HOLD_CNT_W-1:0] hold_cnt, hold_cnt_d;
  logic                  pick_any;
  logic [SEL_W-1:0]      pick_idx;
  logic                  xfer;
  logic                  release_now;

  rr_pick4 u_pick (
    .req (req),
    .ptr (ptr),
    .any (pick_any),
    .idx (pick_idx)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      gnt      <= '0;
      sel      <= '0;
      ptr      <= '0;
      hold_cnt <= '0;
    end else begin
      state    <= state_d;
      gnt      <= gnt_d;
      sel      <= sel_d;
      ptr      <= ptr_d;
      hold_cnt <= hold_cnt_d;
    end
  end

  always_comb begin
    state_d     = state;
    gnt_d       = gnt;
    sel_d       = sel;
    ptr_d       = ptr;
    hold_cnt_d  = hold_cnt;
    out_valid   = 1'b0;
    xfer        = 1'b0;
    release_now = 1'b0;

    case (state)
      ST_IDLE: begin
        if (pick_any) begin
          state_d    = ST_GRANT;
          sel_d      = pick_idx;
          gnt_d      = onehot_of(pick_idx);
          hold_cnt_d = '0;
        end
      end
      ST_GRANT: begin
        out_valid = req[sel];
        xfer      = out_valid && ready;
        if (!req[sel]) begin
          release_now = 1'b1;
        end else if (xfer) begin
          hold_cnt_d = hold_cnt + HOLD_CNT_W'(1);
          if (hold_cnt == HOLD_LAST) begin
            release_now = 1'b1;
          end
        end
        // Released requester drops to lowest priority for the next pick.
        if (release_now) begin
          state_d = ST_IDLE;
          gnt_d   = '0;
          ptr_d   = sel + SEL_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        gnt_d   = '0;
      end
    endcase
  end

  always_comb begin
    out_data = data[int'(sel)*DATA_W +: DATA_W];
  end

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Scoreboard bench for mux4_rr_arbiter: a requester-level model predicts each
// cycle's outputs and every accepted transfer; a monitor pops and compares.
module tb_mux4_rr_arbiter;
  import mux4_rr_arbiter_pkg::*;

  localparam int DW = 3;
  localparam int MH = 8;

  logic            clk = 1'b0;
  logic            rst;
  logic [3:0]      req;
  logic [4*DW-1:0] data;
  logic            ready;
  logic [3:0]      gnt;
  logic [1:0]      sel;
  logic            out_valid;
  logic [DW-1:0]   out_data;

  mux4_rr_arbiter #(.DATA_W(DW), .MAX_HOLD(MH)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .data      (data),
    .ready     (ready),
    .gnt       (gnt),
    .sel       (sel),
    .out_valid (out_valid),
    .out_data  (out_data)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0]    gnt;
    logic [1:0]    sel;
    logic          vld;
    logic [DW-1:0] dat;
  } exp_t;

  typedef struct packed {
    logic [1:0]    who;
    logic [DW-1:0] dat;
  } xfer_t;

  exp_t  cyc_q[$];
  xfer_t xfer_q[$];
  int    checks   = 0;
  int    failures = 0;
  bit    running  = 1'b0;

  // Model: who owns the output (-1 = nobody), how many transfers it has had,
  // and who was released last (lowest priority next time).
  int         m_owner;
  int         m_served;
  int         m_last;
  logic [1:0] m_sel;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic model_edge();
    if (rst) begin
      m_owner  = -1;
      m_served = 0;
      m_last   = 3;
      m_sel    = 2'd0;
    end else if (m_owner < 0) begin
      if (req != 4'b0000) begin
        for (int k = 1; k <= 4; k++) begin
          int c;
          c = (m_last + k) % 4;
          if (m_owner < 0 && req[c]) m_owner = c;
        end
        m_sel    = 2'(m_owner);
        m_served = 0;
      end
    end else if (!req[m_owner]) begin
      m_last  = m_owner;
      m_owner = -1;
    end else if (ready) begin
      m_served++;
      if (m_served == MH) begin
        m_last  = m_owner;
        m_owner = -1;
      end
    end
  endtask

  task automatic drive(input logic [3:0] r, input logic rdy, input logic rs);
    exp_t  e;
    xfer_t x;
    req   = r;
    ready = rdy;
    rst   = rs;
    data  = (4*DW)'($urandom());
    e.gnt = (m_owner < 0) ? 4'b0000 : 4'(1 << m_owner);
    e.sel = m_sel;
    e.vld = (m_owner >= 0) && r[m_owner];
    e.dat = data[m_sel*DW +: DW];
    cyc_q.push_back(e);
    if (e.vld && rdy) begin
      x.who = m_sel;
      x.dat = e.dat;
      xfer_q.push_back(x);
    end
    running = 1'b1;
  endtask

  task automatic cycle(input logic [3:0] r, input logic rdy, input logic rs);
    @(posedge clk);
    #1;
    model_edge();
    drive(r, rdy, rs);
  endtask

  task automatic cycles(input int n, input logic [3:0] r, input logic rdy);
    for (int i = 0; i < n; i++) cycle(r, rdy, 1'b0);
  endtask

  always @(negedge clk) begin
    if (running) begin
      if (cyc_q.size() == 0) begin
        chk("cycle_queue_empty", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = cyc_q.pop_front();
        chk("gnt", 32'(gnt), 32'(e.gnt));
        chk("sel", 32'(sel), 32'(e.sel));
        chk("out_valid", 32'(out_valid), 32'(e.vld));
        chk("out_data", 32'(out_data), 32'(e.dat));
      end
      chk("inv_onehot0", 32'($onehot0(gnt)), 32'd1);
      chk("inv_gnt_iff_grant", 32'(gnt != 4'b0000), 32'(dut.state == ST_GRANT));
      if (gnt != 4'b0000) chk("inv_gnt_sel", 32'(gnt[sel]), 32'd1);
      if (out_valid && ready) begin
        if (xfer_q.size() == 0) begin
          chk("unexpected_transfer", 32'd1, 32'd0);
        end else begin
          xfer_t x;
          x = xfer_q.pop_front();
          chk("xfer_who", 32'(sel), 32'(x.who));
          chk("xfer_data", 32'(out_data), 32'(x.dat));
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] r;
    logic       rdy;
    rst   = 1'b1;
    req   = 4'b0000;
    ready = 1'b0;
    data  = '0;

    for (int i = 0; i < 3; i++) cycle(4'b0000, 1'b0, 1'b1);

    // Single requester 2 after reset.
    cycles(4, 4'b0100, 1'b1);
    cycles(2, 4'b0000, 1'b1);

    // All requesting: rotation and MAX_HOLD limit.
    cycles(4 * (MH + 1) + MH + 1, 4'b1111, 1'b1);
    cycles(2, 4'b0000, 1'b1);

    // Requester 1 stalled by ready low, then resumes.
    cycles(20, 4'b0010, 1'b0);
    cycles(12, 4'b0010, 1'b1);
    cycles(2, 4'b0000, 1'b1);

    // Requester 3 drops after 3 transfers; requester 0 follows.
    cycles(4, 4'b1000, 1'b1);
    cycles(5, 4'b0001, 1'b1);
    cycles(2, 4'b0000, 1'b1);

    // Reset in the middle of a grant to requester 2 with hold_cnt at 5.
    cycles(6, 4'b0100, 1'b1);
    cycle(4'b0100, 1'b1, 1'b1);
    cycles(5, 4'b0101, 1'b1);
    cycles(2, 4'b0000, 1'b1);

    // Quiet bus.
    cycles(10, 4'b0000, 1'b1);

    // Randomised traffic with slowly changing requests and occasional reset.
    r = 4'b0000;
    for (int i = 0; i < 2000; i++) begin
      for (int b = 0; b < 4; b++) begin
        if ($urandom_range(0, 7) == 0) r[b] = ~r[b];
      end
      rdy = ($urandom_range(0, 3) != 0);
      cycle(r, rdy, ($urandom_range(0, 199) == 0));
    end

    @(negedge clk);
    #1;
    running = 1'b0;
    chk("cycle_queue_drained", 32'(cyc_q.size()), 32'd0);
    chk("xfer_queue_drained", 32'(xfer_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mux4_rr_arbiter.md
Name: mux4_rr_arbiter

Overview:
- Round-robin arbiter and sequencer for the shared 4-to-1 selector datapath.
- Four requesters compete for one downstream output. The block chooses the winner and drives the 2-bit select.
- It forwards the winner's data through the selector with a valid/ready handshake.
- It bounds each grant to MAX_HOLD transfers so that no requester starves.

Parameters:
- DATA_W, 1, width of each requester's data lane (1 matches the bit-level selector).
- MAX_HOLD, 8, maximum accepted transfers per grant before forced release (legal range 1..255).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- req  input  4  request per requester; bit i belongs to requester i.
- data  input  4*DATA_W  requester data; lane i is data[i*DATA_W +: DATA_W].
- ready  input  1  downstream accepts out_data this cycle.
- gnt  output  4  one-hot grant (all zeros when idle), registered.
- sel  output  2  selector control = index of the granted requester, registered.
- out_valid  output  1  out_data is valid this cycle.
- out_data  output  DATA_W  selected lane, combinational mux of data by sel.

Behaviour:
- Clock and reset: one clock (clk); rst is synchronous, active-high. Reset is sampled only on the rising edge.
- Reset values: state=IDLE, gnt=4'b0000, sel=2'b00, ptr=2'b00, hold_cnt=0, out_valid=0. out_data equals lane 0 while sel=0.
- IDLE state:
  - If req==0, stay in IDLE.
  - Otherwise pick the first set req bit, scanning ptr, ptr+1, ptr+2, ptr+3 (mod 4).
  - At the next edge: load sel=winner, gnt=1<<winner, clear hold_cnt, go to GRANT.
  - Latency from req to gnt is 1 cycle.
- GRANT state:
  - out_valid = req[sel] (combinational). No valid is presented in IDLE.
  - A transfer occurs when out_valid && ready. Each transfer increments hold_cnt.
  - Release when req[sel]==0, or when a transfer occurs with hold_cnt==MAX_HOLD-1.
  - On release, at the next edge: gnt=0, ptr=sel+1 (wrap 3->0), state=IDLE.
  - There is exactly one idle cycle between consecutive grants.
- Simultaneous events:
  - req[sel] falls while ready=1: no transfer; release.
  - ready low with req[sel] high: grant is held indefinitely and hold_cnt is frozen. There is no timeout.
  - Other req bits changing during GRANT are ignored until IDLE.
- Fairness: after requester i is released, it has the lowest priority in the next arbitration. With all four requesting, grants rotate 0,1,2,3,0.
- Reset mid-GRANT: all state returns to reset values at that edge. An in-flight transfer in the same cycle still counts as accepted downstream, but no state records it.
- Width rules:
  - hold_cnt is 8 bits; compare against MAX_HOLD-1 with equal width.
  - ptr and sel arithmetic are 2-bit modulo 4.
- Invariants (assert in bench):
  - gnt is one-hot or zero.
  - gnt!=0 iff state==GRANT.
  - When gnt!=0, gnt[sel]==1.

Decomposition:
- Shared header/package:
  - NREQ=4, SEL_W=2.
  - State encodings ST_IDLE=1'b0, ST_GRANT=1'b1.
  - HOLD_CNT_W=8.
- Sub-module rr_pick4: purely combinational rotating priority picker.
  - Inputs: req[3:0], ptr[1:0].
  - Outputs: any, idx[1:0].
  - Reused by later arbiters.
- The selector itself stays inline as the out_data mux.

Test Plan:
- Reset then req=4'b0100, ready=1 -> gnt=4'b0100 and sel=2 one cycle later; out_valid=1 and out_data=lane 2.
- req=4'b1111 held, ready=1, MAX_HOLD=8 -> each grant lasts 8 transfer cycles plus 1 idle cycle; order is sel 0,1,2,3,0.
- Requester 1 holds req, ready=0 for 20 cycles -> gnt=4'b0010 stays, hold_cnt stays 0, out_valid=1. Raise ready -> transfers resume.
- Granted requester 3 drops req after 3 transfers while req[0]=1 -> release, next grant to requester 0 (ptr wrapped to 0) two cycles after the drop.
- rst asserted mid-GRANT (sel=2, hold_cnt=5) -> next cycle gnt=0, sel=0, ptr=0, out_valid=0. With req=4'b0101 after reset, requester 0 wins first.
- req=4'b0000 for 10 cycles -> gnt stays 0, out_valid stays 0, state stays IDLE.
